// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI read-address generator.
package axi_rd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ISSUE,
    DRAIN,
    FIN
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int AXI_MAX_BEATS = 16;
  localparam int AXI_4K_BYTES = 4096;

  function automatic logic [2:0] size_of(input int dw);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((8 << i) == dw) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/axi_rd_addr_channel.sv
// AXI3 read-address channel bundle.
interface axi_rd_addr_channel #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [ID_WIDTH-1:0]   arid;
  logic [3:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [3:0]            arqos;
  logic [3:0]            arregion;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst,
    output arlock, arcache, arprot, arqos, arregion,
    input  arready
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arqos, arregion,
    output arready
  );
endinterface

// File: rtl/axi_burst_split.sv
// Combinational burst sizing: min(remaining, 16, beats to next 4 KB page).
module axi_burst_split
  import axi_rd_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int BEAT_CNT_WIDTH = 16
) (
  input  logic [ADDR_WIDTH-1:0]     cur_addr,
  input  logic [BEAT_CNT_WIDTH-1:0] rem_beats,
  input  logic [2:0]                size,
  output logic [4:0]                burst_beats,
  output logic [ADDR_WIDTH-1:0]     next_addr,
  output logic [BEAT_CNT_WIDTH-1:0] next_rem
);

  logic [12:0] to_4k;
  logic [4:0]  cap;

  // 13 bits so a page-aligned address yields a full 4096 bytes
  assign to_4k = (13'(AXI_4K_BYTES) - {1'b0, cur_addr[11:0]}) >> size;

  assign cap = (rem_beats < BEAT_CNT_WIDTH'(AXI_MAX_BEATS))
             ? rem_beats[4:0] : 5'(AXI_MAX_BEATS);

  assign burst_beats = (to_4k < {8'd0, cap}) ? to_4k[4:0] : cap;

  assign next_addr = cur_addr + (ADDR_WIDTH'(burst_beats) << size);
  assign next_rem  = rem_beats - BEAT_CNT_WIDTH'(burst_beats);

endmodule

// File: rtl/axi_rd_addr_gen.sv
// Splits fetch requests into AXI3 INCR bursts on the AR channel.
// Define AXI_RD_OT_LIMIT_EN to cap outstanding bursts at MAX_OT.
module axi_rd_addr_gen
  import axi_rd_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_MAX_WIDTH   = 4,
  parameter int BEAT_CNT_WIDTH = 16,
  parameter int MAX_OT         = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [BEAT_CNT_WIDTH-1:0] req_beats,
  input  logic [ID_MAX_WIDTH-1:0]   req_id,
  input  logic                      rlast_done,
  axi_rd_addr_channel.master        m_ar,
  output logic                      busy,
  output logic                      done
);

  localparam logic [2:0] SIZE = size_of(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << SIZE;

  state_t                    state;
  logic [ADDR_WIDTH-1:0]     cur_addr;
  logic [BEAT_CNT_WIDTH-1:0] rem_beats;
  logic [ID_MAX_WIDTH-1:0]   cur_id;
  logic [4:0]                burst_beats;
  logic [4:0]                split_beats;
  logic [ADDR_WIDTH-1:0]     next_addr;
  logic [BEAT_CNT_WIDTH-1:0] next_rem;
  logic                      ar_hs;
  logic                      ot_ok;

  assign ar_hs = m_ar.arvalid && m_ar.arready;

  axi_burst_split #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .BEAT_CNT_WIDTH(BEAT_CNT_WIDTH)
  ) u_split (
    .cur_addr   (cur_addr),
    .rem_beats  (rem_beats),
    .size       (SIZE),
    .burst_beats(split_beats),
    .next_addr  (next_addr),
    .next_rem   (next_rem)
  );

`ifdef AXI_RD_OT_LIMIT_EN
  localparam int OTW = $clog2(MAX_OT + 1);
  logic [OTW-1:0] ot_cnt;
  logic           ot_dec;

  // completions with nothing outstanding are dropped
  assign ot_dec = rlast_done && (ot_cnt != '0);
  assign ot_ok  = (ot_cnt != OTW'(MAX_OT));

  always_ff @(posedge clk) begin
    if (rst) ot_cnt <= '0;
    else if (ar_hs && !ot_dec) ot_cnt <= ot_cnt + 1'b1;
    else if (!ar_hs && ot_dec) ot_cnt <= ot_cnt - 1'b1;
  end
`else
  logic unused_ot;
  assign unused_ot = rlast_done ^ (MAX_OT == 0);
  assign ot_ok     = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      cur_addr      <= '0;
      rem_beats     <= '0;
      cur_id        <= '0;
      burst_beats   <= '0;
      m_ar.arvalid  <= 1'b0;
      m_ar.araddr   <= '0;
      m_ar.arid     <= '0;
      m_ar.arlen    <= '0;
      m_ar.arsize   <= '0;
      m_ar.arburst  <= '0;
      m_ar.arlock   <= 1'b0;
      m_ar.arcache  <= '0;
      m_ar.arprot   <= '0;
      m_ar.arqos    <= '0;
      m_ar.arregion <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            cur_addr  <= req_addr & ADDR_MASK;
            rem_beats <= req_beats;
            cur_id    <= req_id;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_beats == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          burst_beats   <= split_beats;
          m_ar.araddr   <= cur_addr;
          m_ar.arid     <= cur_id;
          m_ar.arlen    <= 4'(split_beats - 5'd1);
          m_ar.arsize   <= SIZE;
          m_ar.arburst  <= AXI_BURST_INCR;
          m_ar.arcache  <= 4'b0011;
          m_ar.arvalid  <= ot_ok;
          state         <= ISSUE;
        end
        ISSUE: begin
          if (ar_hs) begin
            m_ar.arvalid <= 1'b0;
            cur_addr     <= next_addr;
            rem_beats    <= rem_beats - BEAT_CNT_WIDTH'(burst_beats);
            if (next_rem != '0) begin
              state <= CALC;
            end else begin
`ifdef AXI_RD_OT_LIMIT_EN
              state <= DRAIN;
`else
              state <= FIN;
              done  <= 1'b1;
`endif
            end
          end else if (!m_ar.arvalid && ot_ok) begin
            m_ar.arvalid <= 1'b1;
          end
        end
`ifdef AXI_RD_OT_LIMIT_EN
        DRAIN: begin
          if (ot_cnt == '0) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
`endif
        FIN: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_rd_addr_gen.md
# axi_rd_addr_gen

Read-address generator driving the master side of `axi_rd_addr_channel`. It accepts one fetch request per command: start address, beat count and ID. It splits the request into AXI3 INCR bursts of at most 16 beats that never cross a 4 KB boundary, and issues them on the AR channel. It sits between the CNN feature-map/weight fetch controllers and the AXI read port. The R-channel consumer feeds back burst completions.

## Interface
- `ADDR_WIDTH`, 32, AR address width
- `DATA_WIDTH`, 32, R data width in bits; power of two, 32..1024
- `ID_MAX_WIDTH`, 4, AR ID width
- `BEAT_CNT_WIDTH`, 16, width of request beat count
- `MAX_OT`, 4, maximum outstanding bursts (used only with `AXI_RD_OT_LIMIT_EN`)

Ports:
- `clk`  in  1  clock, all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  block idle, request accepted when both high
- `req_addr`  in  ADDR_WIDTH  start byte address; low log2(DATA_WIDTH/8) bits ignored (forced to 0)
- `req_beats`  in  BEAT_CNT_WIDTH  total beats to fetch
- `req_id`  in  ID_MAX_WIDTH  ID placed on every burst of this request
- `rlast_done`  in  1  one-cycle pulse per completed burst (rvalid&rready&rlast)
- `m_ar`  modport  `axi_rd_addr_channel.master`  AR channel
- `busy`  out  1  high from request accept until done
- `done`  out  1  one-cycle pulse at request completion

## Operation
- The following AR fields are constant:
  - `arsize` = log2(DATA_WIDTH/8)
  - `arbrust` = 2'b01 (INCR)
  - `arlock` = 0
  - `arcache` = 4'b0011
  - `arprot` = 0
  - `arqos` = 0
  - `arregion` = 0
- Registers: `cur_addr`, `rem_beats`, `cur_id`, `burst_beats` (5 bits, 1..16).
- Burst size: burst_beats = min(rem_beats, 16, beats_to_4k), where beats_to_4k = (4096 − cur_addr[11:0]) >> arsize.
  - Arithmetic is 13 bits so that 4096 is representable.
  - `arlen` = burst_beats − 1.
- FSM states:
  - IDLE: `req_ready`=1. On accept, load the registers and go to CALC. If `req_beats`==0, go to FIN instead.
  - CALC: register burst_beats and the AR fields, then go to ISSUE.
  - ISSUE: `arvalid`=1, fields stable until the `arready` handshake. On handshake:
    - cur_addr += burst_beats<<arsize
    - rem_beats −= burst_beats
    - if the result is nonzero, go to CALC; otherwise go to DRAIN (with macro) or FIN (without).
  - DRAIN: wait until the outstanding count is 0, then go to FIN.
  - FIN: `done`=1 for one cycle, then go to IDLE.
- `busy` = state≠IDLE.
- Reset values: state IDLE, `arvalid` 0, all AR fields 0, `req_ready` 1, `busy` 0, `done` 0, counters 0.
- Reset mid-transfer: everything returns to reset values on the next edge, and the current request is abandoned. The system resets the AXI slave concurrently.
- `req_valid` while busy is ignored (`req_ready` is low).

## Timing
- Request accept at cycle N: CALC at N+1, `arvalid` high at N+2.
- AR handshake at cycle M with beats remaining: `arvalid` low at M+1 (CALC), high again at M+2. This one-bubble cadence is the required behaviour.
- The last handshake goes to FIN (or DRAIN) at M+1. `done` pulses at M+1 when there is no DRAIN.
- Zero-beat request accepted at N: `done` at N+1, and no `arvalid` is ever raised.
- `arvalid` never drops before `arready`. No field changes while `arvalid`=1 and `arready`=0.

## Configuration
- `AXI_RD_OT_LIMIT_EN` defined:
  - `ot_cnt` (width clog2(MAX_OT+1)) increments on each AR handshake and decrements on `rlast_done`. A simultaneous increment and decrement leaves it unchanged.
  - ISSUE holds `arvalid` low while `ot_cnt`==MAX_OT.
  - The DRAIN state exists.
  - A `rlast_done` pulse with `ot_cnt`==0 is ignored, and the count saturates at 0.
- Not defined: no counter and no DRAIN state; `rlast_done` is unused; `arvalid` is raised in ISSUE without gating.

## Structure
- A shared package `axi_rd_pkg` holds:
  - the FSM state enum
  - `AXI_BURST_INCR`, `AXI_MAX_BEATS` (16) and `AXI_4K_BYTES` (4096)
  - a `size_of(DATA_WIDTH)` function
- One natural sub-module, `axi_burst_split`: the combinational burst-size calculation (cur_addr, rem_beats → burst_beats, next_addr, next_rem).

## Test plan
All scenarios use DATA_WIDTH=32 (`arsize`=2) unless stated.
- Aligned split: addr 0x1000, 40 beats, `arready`=1 → three bursts: (0x1000, len 15), (0x1040, len 15), (0x1080, len 7); `done` one cycle after the third handshake.
- 4K crossing: addr 0x0FF8, 8 beats → (0x0FF8, len 1), (0x1000, len 5).
- Back-pressure: `arready` held low 5 cycles → `arvalid`, `araddr` and `arlen` stay constant; exactly one handshake occurs.
- OT limit (macro on, MAX_OT=2): 64 beats, no `rlast_done` → exactly 2 handshakes, then `arvalid` stays low. One `rlast_done` pulse → third burst issued. `done` fires only after 4 pulses.
- Zero beats: `req_beats`=0 → `arvalid` never asserted; `done` at N+1.
- Reset mid-burst: `rst` high while `arvalid`=1 → next cycle `arvalid`=0 and `req_ready`=1. A new request of 4 beats at 0x2000 then gives (0x2000, len 3).
